// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment display slice.
package display_pkg;

    // Largest digit count the scanner supports.
    localparam int MAX_DIGITS = 8;

    // All segments dark in the active-high internal form.
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Clock cycles spent on each digit slot (integer division).
    function automatic int ticks_per_digit(input int clock_hz, input int refresh_hz, input int n);
        return clock_hz / (refresh_hz * n);
    endfunction

endpackage

// File: rtl/binary_to_7seg.sv
// Hex nibble to seven-segment pattern, segment order {g,f,e,d,c,b,a}.
module binary_to_7seg #(
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    logic [6:0] seg_hi;

    // Active-high segment pattern for each hex value.
    always_comb begin
        seg_hi = 7'h00;
        case (bin)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            default: seg_hi = 7'h71;
        endcase
    end

    assign seg = COMMON_ANODE ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for 1..8 seven-segment digits. Inputs are
// shadowed at frame boundaries so a frame never mixes old and new values.
module seven_seg_scanner
    import display_pkg::*;
#(
    parameter bit COMMON_ANODE = 1'b1,
    parameter int NUM_DIGITS   = 8,
    parameter int CLOCK_HZ     = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int T  = ticks_per_digit(CLOCK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int TW = (T > 1) ? $clog2(T) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Pin-level "off" values; polarity is applied only at the output flops.
    localparam logic [6:0]            SEG_RST = COMMON_ANODE ? ~SEG_OFF : SEG_OFF;
    localparam logic                  DP_RST  = COMMON_ANODE;
    localparam logic [NUM_DIGITS-1:0] AN_RST  = COMMON_ANODE ? '1 : '0;

    generate
        if (T < 2) begin : g_bad_t
            $error("seven_seg_scanner: ticks per digit must be at least 2");
        end
        if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_n
            $error("seven_seg_scanner: NUM_DIGITS out of range");
        end
    endgenerate

    // Scan position and frame bookkeeping.
    logic [TW-1:0] tick_q, tick_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          init_q, init_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_off_q, blink_off_d;

    // Shadowed inputs, stable for a whole frame.
    logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
    logic [NUM_DIGITS-1:0]   lz_mask_q, lz_mask_d;
    logic [TW-1:0]           on_ticks_q, on_ticks_d;

    // Output registers, held in pin polarity.
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_start_q, frame_start_d;

    logic       frame_end;
    logic       capture;
    logic [3:0] nibble;
    logic [6:0] seg_code;

    assign frame_end = (tick_q == TW'(T - 1)) && (idx_q == IW'(NUM_DIGITS - 1));
    assign capture   = init_q || frame_end;
    assign nibble    = sh_digits_q[{idx_q, 2'b00} +: 4];

    binary_to_7seg #(
        .COMMON_ANODE(1'b0)
    ) u_dec (
        .bin(nibble),
        .seg(seg_code)
    );

    // Scan counters, frame/blink tracking and frame-boundary input capture.
    always_comb begin
        logic all_zero;
        int   on_calc;
        tick_d      = (tick_q == TW'(T - 1)) ? '0 : tick_q + 1'b1;
        idx_d       = idx_q;
        if (tick_q == TW'(T - 1)) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        init_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        blink_off_d = blink_off_q;
        if (frame_end) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        sh_digits_d = sh_digits_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        sh_blink_d  = sh_blink_q;
        lz_mask_d   = lz_mask_q;
        on_ticks_d  = on_ticks_q;
        all_zero    = 1'b1;
        on_calc     = ((int'(brightness) + 1) * (T - 1)) >>> BRIGHT_W;
        if (capture) begin
            sh_digits_d = digits;
            sh_dp_d     = dp_in;
            sh_blank_d  = blank_mask;
            sh_blink_d  = blink_mask;
            on_ticks_d  = TW'(on_calc);
            // Walk from the leftmost digit; a digit is a leading zero while
            // it and everything to its left are zero. Digit 0 always shows.
            for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
                all_zero     = all_zero && (digits[4*k +: 4] == 4'h0);
                lz_mask_d[k] = lz_suppress && (k >= 1) && all_zero;
            end
        end
    end

    // Next values of the pins: dead cycle 0, PWM window, blank and blink gating.
    always_comb begin
        logic                  lit;
        logic [6:0]            seg_hi;
        logic [NUM_DIGITS-1:0] an_hi;
        lit = (tick_q != '0) && (tick_q <= on_ticks_q) && !sh_blank_q[idx_q]
              && !(blink_off_q && sh_blink_q[idx_q]);
        seg_hi = (lit && !lz_mask_q[idx_q]) ? seg_code : SEG_OFF;
        an_hi  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_hi[k] = lit && (idx_q == IW'(k));
        end
        seg_d         = COMMON_ANODE ? ~seg_hi : seg_hi;
        dp_out_d      = COMMON_ANODE ? ~(lit && sh_dp_q[idx_q]) : (lit && sh_dp_q[idx_q]);
        an_d          = COMMON_ANODE ? ~an_hi : an_hi;
        frame_start_d = (tick_q == '0) && (idx_q == '0);
    end

    // All state, with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_q        <= '0;
            idx_q         <= '0;
            init_q        <= 1'b1;
            frame_cnt_q   <= '0;
            blink_off_q   <= 1'b0;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            sh_blink_q    <= '0;
            lz_mask_q     <= '0;
            on_ticks_q    <= '0;
            seg_q         <= SEG_RST;
            dp_out_q      <= DP_RST;
            an_q          <= AN_RST;
            frame_start_q <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            init_q        <= init_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_off_q   <= blink_off_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_blink_q    <= sh_blink_d;
            lz_mask_q     <= lz_mask_d;
            on_ticks_q    <= on_ticks_d;
            seg_q         <= seg_d;
            dp_out_q      <= dp_out_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_out_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised time-multiplexed driver for 1–8 seven-segment digits.
- Displays a packed hex word and adds per-digit decimal points, leading-zero suppression, a blank mask, frame-synchronous blinking and PWM brightness.
- Inputs are captured only at frame boundaries, so the display never tears.
- Sits between the UART status/data registers and the board's digit/segment pins.

## Interface
Parameters:
- COMMON_ANODE, 1, 1 = active-low seg/dp/an; 0 = active-high
- NUM_DIGITS, 8, digit count (1..8)
- CLOCK_HZ, 50_000_000, clk frequency
- REFRESH_HZ, 1000, full-frame refresh rate
- BRIGHT_W, 4, brightness control width
- BLINK_FRAMES, 250, frames per blink half-period

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- digits  in  4*NUM_DIGITS  hex nibbles; digit k = digits[4k+3:4k]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit
- blank_mask  in  NUM_DIGITS  1 = digit always dark
- blink_mask  in  NUM_DIGITS  1 = digit dark during blink-off phase
- lz_suppress  in  1  enable leading-zero suppression
- brightness  in  BRIGHT_W  0 = dimmest, all-ones = full
- seg  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- an  out  NUM_DIGITS  digit enables
- frame_start  out  1  one-cycle pulse when slot 0 begins

## Operation
- T = CLOCK_HZ/(REFRESH_HZ*NUM_DIGITS), integer division. Elaboration error if T < 2.
- tick_cnt counts 0..T-1. At the wrap, idx advances 0..NUM_DIGITS-1 and wraps to 0.
- Shadow capture of all inputs happens on the first clock after rstn deasserts, and on every cycle where tick_cnt==T-1 and idx==NUM_DIGITS-1. Captured inputs: digits, dp_in, masks, lz_suppress, brightness.
- The shadow capture also registers:
  - lz_mask: digit k is suppressed iff lz_suppress=1, k≥1, and digits k..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
  - on_ticks = ((brightness+1)*(T-1)) >> BRIGHT_W.
- Digit idx is lit iff all of the following hold:
  - tick_cnt ≥ 1 (cycle 0 is anti-ghost dead time)
  - tick_cnt ≤ on_ticks
  - not blank_mask[idx]
  - not (blink_off and blink_mask[idx])
- A lit digit drives seg from its nibble, unless lz_mask[idx] is set, in which case seg is off. dp = dp_in[idx].
- A lit but lz-suppressed digit still shows dp.
- When not lit: an all inactive, seg off, dp off.
- Frame counter counts frame_start pulses. blink_off toggles every BLINK_FRAMES frames. blink_off resets to 0.
- Polarity: COMMON_ANODE=1 inverts an, seg and dp relative to the active-high internal form.

## Timing
- seg, dp, an and frame_start are registered: one cycle after the tick_cnt/idx state they reflect.
- Each slot lasts T cycles. an goes active for on_ticks cycles, starting at slot cycle 1.
- The seg code changes only at slot cycle 0, while an is inactive.
- frame_start is high for exactly one cycle, every NUM_DIGITS*T cycles.
- Input changes take effect from the next frame's slot 0.
- Reset values (asserting rstn, even mid-frame, forces these asynchronously):
  - an inactive
  - seg off
  - dp off
  - frame_start 0
  - tick_cnt, idx, frame counter, blink_off all 0
- After rstn release the scan restarts at slot 0, cycle 0.
- brightness=0 gives on_ticks=(T-1)>>BRIGHT_W, which may be 0, giving a permanently dark digit. This is legal.

## Structure
- display_pkg holds:
  - function ticks_per_digit(clock_hz, refresh_hz, n)
  - SEG_OFF constant (active-high 7'h00)
  - MAX_DIGITS=8
- One sub-module: the existing binary_to_7seg, instantiated with COMMON_ANODE=0 (active-high form). Polarity is applied once at the output registers.

## Test plan
Bench parameters: NUM_DIGITS=4, CLOCK_HZ=8000, REFRESH_HZ=250 (T=8), BRIGHT_W=4, COMMON_ANODE=1.
- Reset held → an=4'hF, seg=7'h7F, dp=1. Release → frame_start at first slot 0, then every 32 cycles.
- digits=16'h1234, brightness=4'hF, masks 0 → slot k: an=~(1<<k) on cycles 1..7; seg = encoding of nibble k; cycle 0 all off.
- lz_suppress=1, digits=16'h0050 → digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0. digits=16'h0000 → only digit 0 shows 0.
- brightness=3 → exactly 1 lit cycle per slot. brightness=0 → no digit ever lit.
- Change digits mid-frame → displayed value unchanged until the next frame_start. BLINK_FRAMES=2, blink_mask=4'b0001 → digit 0 dark in frames 2,3,6,7,…
- Assert rstn in slot 2 → outputs go off the same cycle. After release, scanning resumes at slot 0 with a fresh capture.
